baby_control_sequencer: RTL
===========================

# baby_control_sequencer

Instruction-cycle sequencer for the Manchester Baby TTL datapath. Steps each instruction through increment-CI, fetch, decode and execute, and drives the one-cycle enable strobes that are ANDed with data lines in the gating logic to load CI, PI and the accumulator. It also runs the memory request/acknowledge handshake, with a timeout. It sits between the front-panel run/step controls, the store, and the register/ALU datapath.

## Interface
- TIMEOUT, 15: maximum cycles a memory request may wait for MEM_ACK; legal range 1..255.

- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RUN  in  1  level; high means continuous execution.
- STEP  in  1  one-cycle pulse; executes exactly one instruction when sampled in HALT with RUN low.
- OPCODE  in  3  function field from the PI register; sampled in DECODE.
- ACC_NEG  in  1  accumulator sign bit; used by CMP.
- MEM_ACK  in  1  store acknowledge.
- MEM_REQ  out  1  store access request.
- MEM_WE  out  1  write qualifier; valid only while MEM_REQ is high.
- CI_INC  out  1  CI increment strobe.
- CI_LOAD  out  1  CI load strobe (JMP).
- CI_ADD  out  1  CI add strobe (JRP).
- PI_LOAD  out  1  PI load strobe.
- ACC_LOAD_NEG  out  1  accumulator load-negated strobe (LDN).
- ACC_SUB  out  1  accumulator subtract strobe (SUB).
- HALTED  out  1  high in HALT.
- FAULT  out  1  high in FAULT.
- STATE  out  3  current state encoding, for the panel and debug.

## Operation
- States and encodings: HALT=0, INC=1, FETCH=2, DECODE=3, EXEC=4, MEMOP=5, FAULT=6. Encoding 7 is unreachable; if it occurs, the next state is FAULT.
- HALT:
  - RUN=1 → INC, with step flag cleared.
  - RUN=0 and STEP=1 → INC, with step flag set.
  - RUN wins if RUN and STEP are both high.
- INC: CI_INC=1 for one cycle → FETCH.
- FETCH: MEM_REQ=1, MEM_WE=0. On MEM_ACK, PI_LOAD=1 in the same cycle → DECODE.
- DECODE: latch OPCODE into internal OP.
  - OP 0, 1, 6, 7 → EXEC.
  - OP 2, 3, 4, 5 → MEMOP.
- EXEC (one cycle):
  - OP0 JMP: CI_LOAD=1.
  - OP1 JRP: CI_ADD=1.
  - OP6 CMP: CI_INC=ACC_NEG (skip).
  - OP7 STP: no strobe; next state is HALT regardless of RUN.
- MEMOP: MEM_REQ=1, MEM_WE=(OP==3). On MEM_ACK:
  - OP2 LDN: ACC_LOAD_NEG=1.
  - OP4 or OP5 SUB: ACC_SUB=1.
  - OP3 STO: no extra strobe.
- End of instruction (EXEC done, or MEMOP acknowledged), except STP:
  - RUN=1 and step flag clear → INC.
  - Otherwise → HALT.
  - RUN falling mid-instruction lets the current instruction complete, then goes to HALT.
- STEP outside HALT is ignored and not queued.
- Timeout:
  - The request counter clears on entry to FETCH or MEMOP.
  - MEM_ACK is accepted in request cycles 1..TIMEOUT; an ack in cycle TIMEOUT takes priority over the timeout.
  - No ack by cycle TIMEOUT → FAULT on the next edge.
- FAULT is sticky: all strobes and MEM_REQ stay low, and only RESET exits it.
- MEM_ACK outside FETCH/MEMOP is ignored.

## Timing
- Reset value of every output:
  - All strobes, MEM_REQ, MEM_WE and FAULT are 0.
  - HALTED=1, STATE=0.
  - OP, step flag and counter are cleared.
- RESET asserted mid-request drops MEM_REQ immediately (asynchronously).
- Strobes are Mealy outputs qualified by state, OP, MEM_ACK and ACC_NEG. Each strobe is high for exactly one cycle per instruction.
- MEM_REQ and MEM_WE are stable from the first request cycle through the ack cycle, and go low the cycle after the ack.
- Latency with zero-wait memory (ack in the first request cycle): 4 cycles per instruction for both paths (INC, FETCH, DECODE, EXEC/MEMOP). Each wait cycle adds 1.
- HALT to the first CI_INC: 1 cycle after RUN or STEP is sampled.

## Test plan
- Reset, RUN=1, OPCODE=0, immediate ack → CI_INC at cycle 1, PI_LOAD at cycle 2, CI_LOAD at cycle 4, CI_INC again at cycle 5, and every 4 cycles thereafter.
- STEP pulse with RUN=0, OPCODE=3, ack delayed by 2 cycles in MEMOP → MEM_WE=1 for 3 request cycles; return to HALT with HALTED=1 after exactly one instruction.
- OPCODE=6 with ACC_NEG=1, then ACC_NEG=0 → CI_INC in EXEC on the first instruction only.
- TIMEOUT=4:
  - Ack in request cycle 4 → proceeds normally.
  - No ack → FAULT=1, STATE=6 after cycle 4; RUN is ignored; exits only on RESET.
- OPCODE=7 with RUN held high → HALT after EXEC, with no further CI_INC.
- RESET pulsed during a FETCH wait → MEM_REQ=0 within the same cycle, STATE=0; RUN restarts cleanly at INC.

Source files
------------

// File: rtl/baby_control_sequencer_if.sv
// ============================================================================
// baby_control_sequencer_if
// ----------------------------------------------------------------------------
// Bundles every signal between the Manchester Baby instruction sequencer and
// the rest of the machine: front-panel controls, the store handshake, the
// gating strobes into the CI/PI/accumulator datapath, and panel status.
//
// Signals
//   run           panel RUN level, high for continuous execution
//   step          panel STEP pulse, one instruction from HALT
//   opcode[2:0]   function field from the PI register
//   acc_neg       accumulator sign bit (CMP skip condition)
//   mem_ack       store acknowledge
//   mem_req       store access request
//   mem_we        store write qualifier, meaningful only with mem_req
//   ci_inc        CI increment strobe
//   ci_load       CI load strobe (JMP)
//   ci_add        CI add strobe (JRP)
//   pi_load       PI load strobe
//   acc_load_neg  accumulator load-negated strobe (LDN)
//   acc_sub       accumulator subtract strobe (SUB)
//   halted        sequencer is in HALT
//   fault         sequencer is in FAULT
//   state[2:0]    current state encoding for the panel
//
// Modports
//   master  the sequencer: it initiates store requests and drives strobes
//   slave   the environment: panel, store and datapath
// ============================================================================
interface baby_control_sequencer_if;

    logic       run;
    logic       step;
    logic [2:0] opcode;
    logic       acc_neg;
    logic       mem_ack;

    logic       mem_req;
    logic       mem_we;
    logic       ci_inc;
    logic       ci_load;
    logic       ci_add;
    logic       pi_load;
    logic       acc_load_neg;
    logic       acc_sub;
    logic       halted;
    logic       fault;
    logic [2:0] state;

    modport master (
        input  run, step, opcode, acc_neg, mem_ack,
        output mem_req, mem_we, ci_inc, ci_load, ci_add, pi_load,
               acc_load_neg, acc_sub, halted, fault, state
    );

    modport slave (
        output run, step, opcode, acc_neg, mem_ack,
        input  mem_req, mem_we, ci_inc, ci_load, ci_add, pi_load,
               acc_load_neg, acc_sub, halted, fault, state
    );

endinterface

// File: rtl/baby_control_sequencer.sv
// ============================================================================
// baby_control_sequencer
// ----------------------------------------------------------------------------
// Instruction-cycle sequencer for the Manchester Baby TTL datapath. Each
// instruction walks INC -> FETCH -> DECODE -> EXEC or MEMOP. The sequencer
// emits one-cycle strobes that the gating logic ANDs with data lines to load
// CI, PI and the accumulator, and it runs the store request/acknowledge
// handshake with a bounded wait. A request that is not acknowledged within
// TIMEOUT cycles parks the machine in FAULT until reset.
//
// Parameters
//   TIMEOUT   maximum request cycles waiting for mem_ack, legal range 1..255
//
// Ports
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   bus       baby_control_sequencer_if.master (controls, store, strobes,
//             status; see the interface file for the signal list)
//
// State encodings are visible on bus.state:
//   HALT=0 INC=1 FETCH=2 DECODE=3 EXEC=4 MEMOP=5 FAULT=6
// Encoding 7 cannot be reached; if it ever appears the machine faults.
// ============================================================================
module baby_control_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    baby_control_sequencer_if.master        bus
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_INC    = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEMOP  = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    localparam logic [2:0] OP_JMP  = 3'd0;
    localparam logic [2:0] OP_JRP  = 3'd1;
    localparam logic [2:0] OP_LDN  = 3'd2;
    localparam logic [2:0] OP_STO  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_SUB2 = 3'd5;
    localparam logic [2:0] OP_CMP  = 3'd6;
    localparam logic [2:0] OP_STP  = 3'd7;

    // The counter holds (request cycle - 1), so the last cycle in which an
    // ack is still accepted is the one where the counter equals TIMEOUT-1.
    localparam logic [7:0] LAST_REQ = 8'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] op_q,    op_d;     // opcode latched in DECODE
    logic       step_q,  step_d;   // instruction was started by STEP
    logic [7:0] cnt_q,   cnt_d;    // request wait counter

    // Where an ordinary instruction goes once it completes: keep running only
    // under RUN and only if this instruction was not a single step.
    state_e     end_state;
    assign end_state = (bus.run && !step_q) ? S_INC : S_HALT;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_HALT;
            op_q    <= 3'd0;
            step_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and Mealy strobes
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case so that
    // no path through the block leaves one unassigned and infers a latch.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        step_d           = step_q;
        cnt_d            = cnt_q;

        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.ci_inc       = 1'b0;
        bus.ci_load      = 1'b0;
        bus.ci_add       = 1'b0;
        bus.pi_load      = 1'b0;
        bus.acc_load_neg = 1'b0;
        bus.acc_sub      = 1'b0;

        case (state_q)
            S_HALT: begin
                // RUN takes precedence over a coincident STEP.
                if (bus.run) begin
                    state_d = S_INC;
                    step_d  = 1'b0;
                end else if (bus.step) begin
                    state_d = S_INC;
                    step_d  = 1'b1;
                end
            end

            S_INC: begin
                bus.ci_inc = 1'b1;
                cnt_d      = 8'd0;
                state_d    = S_FETCH;
            end

            S_FETCH: begin
                bus.mem_req = 1'b1;
                // An ack in the final permitted cycle beats the timeout.
                if (bus.mem_ack) begin
                    bus.pi_load = 1'b1;
                    state_d     = S_DECODE;
                end else if (cnt_q == LAST_REQ) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DECODE: begin
                op_d  = bus.opcode;
                cnt_d = 8'd0;
                case (bus.opcode)
                    OP_LDN, OP_STO, OP_SUB, OP_SUB2: state_d = S_MEMOP;
                    default:                         state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (op_q)
                    OP_JMP:  bus.ci_load = 1'b1;
                    OP_JRP:  bus.ci_add  = 1'b1;
                    OP_CMP:  bus.ci_inc  = bus.acc_neg;  // skip next word
                    default: ;
                endcase
                state_d = (op_q == OP_STP) ? S_HALT : end_state;
            end

            S_MEMOP: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (op_q == OP_STO);
                if (bus.mem_ack) begin
                    bus.acc_load_neg = (op_q == OP_LDN);
                    bus.acc_sub      = (op_q == OP_SUB) || (op_q == OP_SUB2);
                    state_d          = end_state;
                end else if (cnt_q == LAST_REQ) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------------
    assign bus.halted = (state_q == S_HALT);
    assign bus.fault  = (state_q == S_FAULT);
    assign bus.state  = state_q;

endmodule
